// File: rtl/glip_fifo_pattern_tester.sv
// glip_fifo_pattern_tester: incrementing-sequence checker on fifo_in and burst generator on fifo_out.
// Optional input back-pressure via GLIP_PATTERN_TESTER_STALL_EN.
module glip_fifo_pattern_tester #(
    parameter int WIDTH      = 16,
    parameter int BURST_LEN  = 256,
    parameter int GAP_CYCLES = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     fifo_in_data,
    input  logic                 fifo_in_valid,
    output logic                 fifo_in_ready,
    output logic [WIDTH-1:0]     fifo_out_data,
    output logic                 fifo_out_valid,
    input  logic                 fifo_out_ready,
    input  logic                 gen_en,
    output logic [CNT_WIDTH-1:0] rx_count,
    output logic [CNT_WIDTH-1:0] tx_count,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic                 err_pulse,
    output logic                 synced
);
    localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

    logic                 ready_q, synced_q, err_pulse_q;
    logic [WIDTH-1:0]     expected_q;
    logic [CNT_WIDTH-1:0] rx_q, tx_q, err_q;
    logic                 in_acc, mismatch;

`ifdef GLIP_PATTERN_TESTER_STALL_EN
    logic [15:0] lfsr_q;

    // Fibonacci x^16+x^14+x^13+x^11+1, shifting right; ready drops when the low two bits are zero
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q  <= 16'hACE1;
            ready_q <= 1'b0;
        end else begin
            lfsr_q  <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
            ready_q <= |lfsr_q[1:0];
        end
    end
`else
    always_ff @(posedge clk) begin
        ready_q <= !rst;
    end
`endif

    assign in_acc   = fifo_in_valid & ready_q;
    assign mismatch = synced_q && (fifo_in_data != expected_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            synced_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            expected_q  <= '0;
            rx_q        <= '0;
            err_q       <= '0;
        end else begin
            err_pulse_q <= in_acc && mismatch;
            if (in_acc) begin
                synced_q   <= 1'b1;
                expected_q <= fifo_in_data + WIDTH'(1);
                if (!(&rx_q)) rx_q <= rx_q + CNT_WIDTH'(1);
                if (mismatch && !(&err_q)) err_q <= err_q + CNT_WIDTH'(1);
            end
        end
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             valid_q, out_acc;

    assign out_acc = valid_q & fifo_out_ready;

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        beat_d  = beat_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                beat_d  = '0;
                state_d = gen_en ? BURST : IDLE;
            end
            BURST: begin
                if (out_acc) begin
                    value_d = value_q + WIDTH'(1);
                    beat_d  = beat_q + BW'(1);
                    if (beat_q == BEAT_LAST) begin
                        beat_d  = '0;
                        gap_d   = '0;
                        state_d = GAP_CYCLES > 0 ? GAP : (gen_en ? BURST : IDLE);
                    end
                end
            end
            GAP: begin
                gap_d = gap_q + GW'(1);
                if (gap_q == GAP_LAST) begin
                    beat_d  = '0;
                    state_d = gen_en ? BURST : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            value_q <= '0;
            beat_q  <= '0;
            gap_q   <= '0;
            valid_q <= 1'b0;
            tx_q    <= '0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
            valid_q <= state_d == BURST;
            if (out_acc && !(&tx_q)) tx_q <= tx_q + CNT_WIDTH'(1);
        end
    end

    assign fifo_in_ready  = ready_q;
    assign fifo_out_data  = value_q;
    assign fifo_out_valid = valid_q;
    assign rx_count       = rx_q;
    assign tx_count       = tx_q;
    assign err_count      = err_q;
    assign err_pulse      = err_pulse_q;
    assign synced         = synced_q;
endmodule
